res_stream_sequencer: RTL and testbench
=======================================

// Module: res_stream_sequencer
// PURPOSE
// Sequences read-out of the Result RAM (filters x dataset x 16 bit) to the UART TX flow controller.
// Owns the Result RAM read port and TX_Start once Compute_Done is seen by the top-level FSM.
// Streams only the filters selected by a mask, honours RAM read latency and the TX_IDLE handshake,
// then pulses Done so the top level can return to RX.
// PARAMETERS
// Bit_width           16   result word width
// Nr_filters           8   filters (Result RAM depth)
// Filter_counter_bits  3   2**n >= Nr_filters
// Nr_dataset         512   words per filter (Result RAM width)
// Dataset_counter_bits 9   2**n >= Nr_dataset
// Ram_rd_latency       1   cycles from RES_read_en to valid RES_data_out (1..3)
// PORTS
// Clk                     in   1                    system clock
// Rst                     in   1                    synchronous reset, active-high
// Start                   in   1                    pulse; begin stream (ignored while Busy)
// Filter_mask             in   Nr_filters           bit f=1 -> send filter f; sampled on accepted Start
// RES_read_en             out  1                    Result RAM read strobe
// RES_read_address_depth  out  Filter_counter_bits  filter index
// RES_read_address_width  out  Dataset_counter_bits word index
// RES_data_out            in   Bit_width            Result RAM read data
// TX_IDLE                 in   1                    UART TX ready
// TX_Start                out  1                    one-cycle send pulse
// TX_data                 out  Bit_width            word to send; stable from TX_Start until TX_IDLE returns high
// Busy                    out  1                    high from accepted Start until Done
// Done                    out  1                    one-cycle pulse at end of stream
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, mask register 0, counters 0; reset mid-stream aborts, no Done.
// - States: IDLE -> SEEK -> READ -> WAIT -> SEND -> ACK -> (READ | SEEK | FIN) -> IDLE.
// - IDLE: Start accepted -> latch mask, Busy=1, filter ptr=0 -> SEEK.
// - SEEK: lowest set mask bit >= ptr chosen in one cycle -> depth=it, width=0 -> READ; none -> FIN.
// - READ: RES_read_en=1 one cycle -> WAIT; WAIT counts Ram_rd_latency cycles, then registers RES_data_out into TX_data.
// - SEND: waits TX_IDLE=1, drives TX_Start=1 one cycle -> ACK. Never pulses while TX_IDLE=0.
// - ACK: waits TX_IDLE=0 (transmitter took word), then: width<Nr_dataset-1 -> width+1, READ;
//   else clear mask bit, ptr=depth+1 -> SEEK (ptr wrap past Nr_filters-1 counts as none).
// - FIN: Done=1 one cycle, Busy=0 -> IDLE. Mask all-zero: Done 2 cycles after Start, no TX_Start.
// - Latency: Start at cycle 0 -> RES_read_en at cycle 2 (SEEK at 1); per word >= Ram_rd_latency+3 cycles.
// - Start during Busy ignored; Filter_mask changes after acceptance ignored.
// - Word count = Nr_dataset x popcount(mask) (+1 with checksum); width never exceeds Nr_dataset-1.
// CONFIGURATION
// - RES_STREAM_CHECKSUM_EN defined: after last data word, FIN preceded by one extra SEND/ACK of
//   TX_data = 16-bit modulo-2**Bit_width sum of all words sent (accumulator cleared on Start/Rst).
// - Undefined: no accumulator, FIN follows last data word directly; all-zero mask sends nothing either way.
// STRUCTURE
// - Package res_stream_pkg: state encoding (one-hot, 7 states), Bit_width/Filter/Dataset width constants.
// - Sub-module res_next_filter: combinational lowest-set-bit-at-or-above-ptr finder (mask, ptr -> idx, found).
// - Top of block: FSM, width counter, latency counter, TX_data register, optional checksum accumulator.
// TESTING
// - Mask 8'h01, RAM word = address, TX model idle 10 cycles/word -> 512 words 0..511, one Done, Busy low after.
// - Mask 8'hA0 -> depths 5 then 7, 1024 words, no read of depth 0..4 or 6; Done once.
// - Mask 8'h00, Start -> Done at cycle 2, TX_Start never high, RES_read_en never high.
// - Ram_rd_latency=3, TX_IDLE held 0 for 50 cycles mid-word -> TX_data stable, no extra TX_Start, no word lost.
// - Rst asserted at word 100 of filter 2 -> next cycle all outputs 0; new Start mask 8'h04 restarts at width 0.
// - RES_STREAM_CHECKSUM_EN, mask 8'h01, words all 16'h0100 -> 513th word = 16'h0000 (512*256 mod 2**16).

Source files
------------

// File: rtl/res_stream_pkg.sv
// Shared constants, state encoding and read-address payload for the result stream sequencer.
package res_stream_pkg;

   localparam int unsigned BIT_WIDTH     = 16;
   localparam int unsigned NR_FILTERS    = 8;
   localparam int unsigned FILT_CNT_BITS = 3;
   localparam int unsigned NR_DATASET    = 512;
   localparam int unsigned DSET_CNT_BITS = 9;
   // One extra bit so a pointer past the last filter means "none left"
   localparam int unsigned PTR_BITS      = FILT_CNT_BITS + 1;
   localparam int unsigned LAT_CNT_BITS  = 2;

   typedef enum logic [6:0] {
      ST_IDLE = 7'b0000001,
      ST_SEEK = 7'b0000010,
      ST_READ = 7'b0000100,
      ST_WAIT = 7'b0001000,
      ST_SEND = 7'b0010000,
      ST_ACK  = 7'b0100000,
      ST_FIN  = 7'b1000000
   } state_e;

   typedef struct packed {
      logic [FILT_CNT_BITS-1:0] depth;
      logic [DSET_CNT_BITS-1:0] width;
   } res_addr_t;

endpackage

// File: rtl/res_next_filter.sv
// Finds the lowest set mask bit at or above the pointer in a single cycle.
module res_next_filter
   import res_stream_pkg::*;
(
   input  logic [NR_FILTERS-1:0]    mask_i,
   input  logic [PTR_BITS-1:0]      ptr_i,
   output logic [FILT_CNT_BITS-1:0] idx_c_o,
   output logic                     found_c_o
);

   // Scan downwards so the last hit written is the lowest qualifying index
   always_comb begin
      idx_c_o   = '0;
      found_c_o = 1'b0;
      for (int i = NR_FILTERS - 1; i >= 0; i--) begin
         if (mask_i[i] && (PTR_BITS'(i) >= ptr_i)) begin
            idx_c_o   = FILT_CNT_BITS'(i);
            found_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/res_stream_sequencer.sv
// Streams mask-selected filters from the Result RAM to the UART TX controller, then pulses done.
// Optional trailing checksum word when RES_STREAM_CHECKSUM_EN is defined.
module res_stream_sequencer
   import res_stream_pkg::*;
#(
   parameter int unsigned RAM_RD_LATENCY = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [NR_FILTERS-1:0]    filter_mask_i,
   output logic                     res_read_en_o,
   output logic [FILT_CNT_BITS-1:0] res_read_address_depth_o,
   output logic [DSET_CNT_BITS-1:0] res_read_address_width_o,
   input  logic [BIT_WIDTH-1:0]     res_data_out_i,
   input  logic                     tx_idle_i,
   output logic                     tx_start_o,
   output logic [BIT_WIDTH-1:0]     tx_data_o,
   output logic                     busy_o,
   output logic                     done_o
);

   state_e                   state_q, state_d;
   logic [NR_FILTERS-1:0]    mask_q, mask_d;
   logic [PTR_BITS-1:0]      ptr_q, ptr_d;
   res_addr_t                addr_q, addr_d;
   logic [LAT_CNT_BITS-1:0]  lat_q, lat_d;
   logic [BIT_WIDTH-1:0]     word_q, word_d;
   logic [BIT_WIDTH-1:0]     tx_data_q, tx_data_d;
   logic                     rd_en_q, rd_en_d;
   logic                     tx_start_q, tx_start_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
`ifdef RES_STREAM_CHECKSUM_EN
   logic [BIT_WIDTH-1:0]     acc_q, acc_d;
   logic                     csum_q, csum_d;
   logic                     any_q, any_d;
`endif

   logic [FILT_CNT_BITS-1:0] next_idx_c;
   logic                     next_found_c;

   res_next_filter u_next_filter (
      .mask_i    (mask_q),
      .ptr_i     (ptr_q),
      .idx_c_o   (next_idx_c),
      .found_c_o (next_found_c)
   );

   // word_q stages the fetched word so tx_data only changes together with tx_start
   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      ptr_d      = ptr_q;
      addr_d     = addr_q;
      lat_d      = lat_q;
      word_d     = word_q;
      tx_data_d  = tx_data_q;
      rd_en_d    = 1'b0;
      tx_start_d = 1'b0;
      done_d     = 1'b0;
      busy_d     = busy_q;
`ifdef RES_STREAM_CHECKSUM_EN
      acc_d      = acc_q;
      csum_d     = csum_q;
      any_d      = any_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               mask_d  = filter_mask_i;
               ptr_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SEEK;
`ifdef RES_STREAM_CHECKSUM_EN
               acc_d   = '0;
               csum_d  = 1'b0;
               any_d   = 1'b0;
`endif
            end
         end
         ST_SEEK: begin
            if (next_found_c) begin
               addr_d.depth = next_idx_c;
               addr_d.width = '0;
               rd_en_d      = 1'b1;
               state_d      = ST_READ;
            end
`ifdef RES_STREAM_CHECKSUM_EN
            else if (any_q && !csum_q) begin
               word_d  = acc_q;
               csum_d  = 1'b1;
               state_d = ST_SEND;
            end
`endif
            else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_FIN;
            end
         end
         ST_READ: begin
            lat_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_q == LAT_CNT_BITS'(RAM_RD_LATENCY - 1)) begin
               word_d  = res_data_out_i;
               state_d = ST_SEND;
`ifdef RES_STREAM_CHECKSUM_EN
               acc_d   = acc_q + res_data_out_i;
               any_d   = 1'b1;
`endif
            end else begin
               lat_d = lat_q + LAT_CNT_BITS'(1);
            end
         end
         ST_SEND: begin
            if (tx_idle_i) begin
               tx_data_d  = word_q;
               tx_start_d = 1'b1;
               state_d    = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!tx_idle_i) begin
`ifdef RES_STREAM_CHECKSUM_EN
               if (csum_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_FIN;
               end else
`endif
               if (addr_q.width < DSET_CNT_BITS'(NR_DATASET - 1)) begin
                  addr_d.width = addr_q.width + DSET_CNT_BITS'(1);
                  rd_en_d      = 1'b1;
                  state_d      = ST_READ;
               end else begin
                  mask_d[addr_q.depth] = 1'b0;
                  ptr_d   = PTR_BITS'(addr_q.depth) + PTR_BITS'(1);
                  state_d = ST_SEEK;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         mask_q     <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         lat_q      <= '0;
         word_q     <= '0;
         tx_data_q  <= '0;
         rd_en_q    <= 1'b0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef RES_STREAM_CHECKSUM_EN
         acc_q      <= '0;
         csum_q     <= 1'b0;
         any_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         lat_q      <= lat_d;
         word_q     <= word_d;
         tx_data_q  <= tx_data_d;
         rd_en_q    <= rd_en_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef RES_STREAM_CHECKSUM_EN
         acc_q      <= acc_d;
         csum_q     <= csum_d;
         any_q      <= any_d;
`endif
      end
   end

   assign res_read_en_o            = rd_en_q;
   assign res_read_address_depth_o = addr_q.depth;
   assign res_read_address_width_o = addr_q.width;
   assign tx_start_o               = tx_start_q;
   assign tx_data_o                = tx_data_q;
   assign busy_o                   = busy_q;
   assign done_o                   = done_q;

endmodule

// File: tb/tb_res_stream_sequencer.sv
// Bench for res_stream_sequencer: RAM and UART TX responders plus an expected-word/address model.
module tb_res_stream_sequencer;

   localparam int LAT = 3;
`ifdef RES_STREAM_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_i, start_i, tx_idle_i;
   logic [7:0]  filter_mask_i;
   logic        res_read_en_o, tx_start_o, busy_o, done_o;
   logic [2:0]  dep;
   logic [8:0]  wid;
   logic [15:0] res_data_out_i, tx_data_o;

   always #5 clk = ~clk;

   res_stream_sequencer #(.RAM_RD_LATENCY(LAT)) dut (
      .clk_i                    (clk),
      .rst_i                    (rst_i),
      .start_i                  (start_i),
      .filter_mask_i            (filter_mask_i),
      .res_read_en_o            (res_read_en_o),
      .res_read_address_depth_o (dep),
      .res_read_address_width_o (wid),
      .res_data_out_i           (res_data_out_i),
      .tx_idle_i                (tx_idle_i),
      .tx_start_o               (tx_start_o),
      .tx_data_o                (tx_data_o),
      .busy_o                   (busy_o),
      .done_o                   (done_o)
   );

   int checks = 0, failures = 0;
   bit const_mode;
   int stall_word, mark_idx;
   bit active;
   int cyc, done_cnt, done_cyc, rd_cnt, first_rd_cyc, rx_cnt, tx_cnt;
   logic [15:0] first_word, mark_word, tx_word;
   logic [15:0] exp_q[$];
   logic [11:0] exp_rd[$];
   logic        hv[0:LAT];
   logic [11:0] ha[0:LAT];

   function automatic logic [15:0] ram_word(input logic [11:0] a);
      return const_mode ? 16'h0100 : {4'h0, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model, compare and responders: all sampled/driven on the falling edge
   always @(negedge clk) begin : model
      logic [15:0] sum, w;
      logic [11:0] a;
      if (rst_i) begin
         active = 1'b0;
         exp_q.delete();
         exp_rd.delete();
         tx_cnt = 0;
         tx_idle_i = 1'b1;
         for (int k = 0; k <= LAT; k++) hv[k] = 1'b0;
         res_data_out_i = 16'hDEAD;
      end else begin
         if (active) begin
            cyc++;
            if (done_o) begin
               check("busy_at_done", 32'(busy_o), 0);
               check("words_left", exp_q.size(), 0);
               check("reads_left", exp_rd.size(), 0);
               active = 1'b0;
               done_cnt++;
               done_cyc = cyc;
            end else begin
               check("busy_high", 32'(busy_o), 1);
            end
         end else begin
            check("idle_outputs", {28'h0, busy_o, done_o, tx_start_o, res_read_en_o}, 0);
         end
         if (res_read_en_o) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rd_cnt++;
            if (exp_rd.size() == 0) check("rd_unexpected", exp_rd.size(), 1);
            else check("rd_addr", {20'h0, dep, wid}, {20'h0, exp_rd.pop_front()});
         end
         if (tx_start_o) begin
            check("start_while_tx_busy", 32'(tx_idle_i), 1);
            rx_cnt++;
            if (rx_cnt == 1) first_word = tx_data_o;
            if (rx_cnt == mark_idx) mark_word = tx_data_o;
            if (exp_q.size() == 0) check("tx_unexpected", exp_q.size(), 1);
            else check("tx_word", 32'(tx_data_o), 32'(exp_q.pop_front()));
            tx_word   = tx_data_o;
            tx_cnt    = (rx_cnt == stall_word) ? 60 : 10;
            tx_idle_i = 1'b0;
         end else if (tx_cnt > 0) begin
            check("tx_data_stable", 32'(tx_data_o), 32'(tx_word));
            tx_cnt--;
            if (tx_cnt == 0) tx_idle_i = 1'b1;
         end
         // RAM with LAT-cycle read latency
         for (int k = LAT; k >= 1; k--) begin
            hv[k] = hv[k-1];
            ha[k] = ha[k-1];
         end
         hv[0] = res_read_en_o;
         ha[0] = {dep, wid};
         res_data_out_i = hv[LAT] ? ram_word(ha[LAT]) : 16'hDEAD;
         if (!active && start_i) begin
            active = 1'b1;
            cyc = 0;
            sum = 16'h0;
            for (int f = 0; f < 8; f++) begin
               if (filter_mask_i[f]) begin
                  for (int i = 0; i < 512; i++) begin
                     a = {3'(f), 9'(i)};
                     w = ram_word(a);
                     exp_rd.push_back(a);
                     exp_q.push_back(w);
                     sum = sum + w;
                  end
               end
            end
            if (CSUM != 0 && exp_q.size() != 0) exp_q.push_back(sum);
         end
      end
   end

   task automatic clear_stats();
      rx_cnt = 0;
      rd_cnt = 0;
      first_rd_cyc = -1;
      done_cyc = -1;
      first_word = 16'hFFFF;
      mark_word = 16'hFFFF;
   endtask

   task automatic start_stream(input logic [7:0] m);
      @(posedge clk); #1;
      filter_mask_i = m;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      filter_mask_i = 8'hFF;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt != d0) break;
      end
      check("done_seen", done_cnt, d0 + 1);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outputs"}, {28'h0, busy_o, done_o, tx_start_o, res_read_en_o}, 0);
      check({tag, "_tx_data"}, 32'(tx_data_o), 0);
      check({tag, "_addr"}, {20'h0, dep, wid}, 0);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; filter_mask_i = 8'h00;
      tx_idle_i = 1'b1; res_data_out_i = 16'hDEAD;
      const_mode = 1'b0; stall_word = 0; mark_idx = 0;
      active = 1'b0; done_cnt = 0; tx_cnt = 0; cyc = 0; tx_word = 16'h0;
      for (int k = 0; k <= LAT; k++) begin hv[k] = 1'b0; ha[k] = 12'h0; end
      clear_stats();
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Single filter, word = address, one stalled word
      clear_stats(); stall_word = 200; mark_idx = 512;
      start_stream(8'h01);
      wait_done(20000);
      check("m01_first_rd_cycle", first_rd_cyc, 2);
      check("m01_words", rx_cnt, 512 + CSUM);
      check("m01_reads", rd_cnt, 512);
      check("m01_first_word", 32'(first_word), 32'h0000);
      check("m01_word512", 32'(mark_word), 32'h01FF);
      check("m01_busy_after", 32'(busy_o), 0);

      // Two sparse filters; a Start during the stream must be ignored
      clear_stats(); stall_word = 0; mark_idx = 513;
      start_stream(8'hA0);
      repeat (300) @(posedge clk);
      #1 start_i = 1'b1; filter_mask_i = 8'h01;
      @(posedge clk); #1 start_i = 1'b0;
      wait_done(30000);
      check("mA0_words", rx_cnt, 1024 + CSUM);
      check("mA0_reads", rd_cnt, 1024);
      check("mA0_first_word", 32'(first_word), 32'h0A00);
      check("mA0_word513", 32'(mark_word), 32'h0E00);

      // Empty mask
      clear_stats();
      start_stream(8'h00);
      wait_done(20);
      check("m00_done_cycle", done_cyc, 2);
      check("m00_words", rx_cnt, 0);
      check("m00_reads", rd_cnt, 0);

      // Reset mid-stream, then restart
      clear_stats();
      start_stream(8'h04);
      for (int i = 0; i < 3000 && rx_cnt < 100; i++) @(posedge clk);
      check("rst_reach_word100", rx_cnt, 100);
      @(posedge clk); #1 rst_i = 1'b1;
      @(posedge clk); #1 rst_i = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      clear_stats(); mark_idx = 512;
      start_stream(8'h04);
      wait_done(20000);
      check("m04_words", rx_cnt, 512 + CSUM);
      check("m04_first_word", 32'(first_word), 32'h0400);
      check("m04_word512", 32'(mark_word), 32'h05FF);

`ifdef RES_STREAM_CHECKSUM_EN
      // Constant words: checksum wraps to zero
      const_mode = 1'b1;
      clear_stats(); mark_idx = 513;
      start_stream(8'h01);
      wait_done(20000);
      check("csum_words", rx_cnt, 513);
      check("csum_word513", 32'(mark_word), 32'h0000);
      check("csum_first_word", 32'(first_word), 32'h0100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
